ps2_host_tx: RTL

Host-to-device transmitter for the PS/2 keyboard port: sends one command byte (e.g. 0xED LED set, 0xFF reset) from the FPGA to the keyboard using the PS/2 host request-to-send protocol. It drives the open-drain clock and data lines through active-high pull-low enables and follows device-generated clocks. It reports completion, acknowledgement or failure to the control logic that also consumes the keyboard receive path.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_filter.sv | 72 +++++++
 rtl/ps2_host_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: frame constants, transmit FSM states, parity.
// Used by the host transmitter and the keyboard receive path.
package ps2_pkg;

    localparam int DATA_BITS   = 8;
    localparam int FRAME_EDGES = 11;

    typedef logic [2:0] tx_state_t;

    localparam logic [2:0] TX_IDLE    = 3'd0;
    localparam logic [2:0] TX_INHIBIT = 3'd1;
    localparam logic [2:0] TX_REQ     = 3'd2;
    localparam logic [2:0] TX_SEND    = 3'd3;
    localparam logic [2:0] TX_ACK     = 3'd4;
    localparam logic [2:0] TX_RELEASE = 3'd5;

    // Odd parity: total ones across data and parity bit is odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 input conditioning: 2-flop synchronizers on clock and data,
// glitch filter on the clock and a one-cycle falling-edge strobe.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_filt,
    output logic clk_fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    clk_sync_d;
    logic [1:0]    data_sync_q;
    logic [1:0]    data_sync_d;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          fall_q;
    logic          fall_d;

    // Shift raw pins through two flops into the clk domain.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], clk_in};
        data_sync_d = {data_sync_q[0], data_in};
    end

    // Accept a new clock level only after FILTER_LEN equal samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall_d = filt_q & ~clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Idle PS/2 lines float high, so all levels reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    assign clk_filt  = filt_q;
    assign clk_fall  = fall_q;
    assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send protocol).
// Drives open-drain lines via pull-low enables, follows device clock.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = $clog2(FRAME_EDGES + 1);

    tx_state_t          state_q;
    tx_state_t          state_d;
    logic [DATA_BITS:0] sh_q;
    logic [DATA_BITS:0] sh_d;
    logic [EW-1:0]      edge_q;
    logic [EW-1:0]      edge_d;
    logic [IW-1:0]      inh_q;
    logic [IW-1:0]      inh_d;
    logic [TW-1:0]      to_q;
    logic [TW-1:0]      to_d;
    logic               clk_oe_q;
    logic               clk_oe_d;
    logic               data_oe_q;
    logic               data_oe_d;
    logic               done_q;
    logic               done_d;
    logic               err_q;
    logic               err_d;

    logic               clk_filt;
    logic               clk_fall;
    logic               data_sync;
    logic               timed_out;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_filt  (clk_filt),
        .clk_fall  (clk_fall),
        .data_sync (data_sync)
    );

    assign timed_out = (to_q == TW'(TIMEOUT_CYCLES - 1));

    // Frame sequencing: request, shift bits on device falls, check ACK.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        edge_d    = edge_q;
        inh_d     = inh_q;
        to_d      = to_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_start) begin
                    sh_d     = {odd_parity(tx_data), tx_data};
                    inh_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = TX_INHIBIT;
                end
            end

            TX_INHIBIT: begin
                inh_d = inh_q + 1'b1;
                if (inh_q == IW'(INHIBIT_CYCLES - 2)) begin
                    data_oe_d = 1'b1;
                end
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    state_d = TX_REQ;
                end
            end

            TX_REQ: begin
                clk_oe_d = 1'b0;
                edge_d   = '0;
                to_d     = '0;
                state_d  = TX_SEND;
            end

            TX_SEND: begin
                to_d = to_q + 1'b1;
                if (clk_fall) begin
                    to_d      = '0;
                    edge_d    = edge_q + 1'b1;
                    data_oe_d = ~sh_q[0];
                    sh_d      = {1'b1, sh_q[DATA_BITS:1]};
                    if (edge_q == EW'(FRAME_EDGES - 2)) begin
                        state_d = TX_ACK;
                    end
                end else if (timed_out) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = TX_IDLE;
                end
            end

            TX_ACK: begin
                to_d = to_q + 1'b1;
                if (clk_fall) begin
                    to_d   = '0;
                    edge_d = edge_q + 1'b1;
                    if (!data_sync) begin
                        state_d = TX_RELEASE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = TX_IDLE;
                    end
                end else if (timed_out) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = TX_IDLE;
                end
            end

            TX_RELEASE: begin
                to_d = to_q + 1'b1;
                if (clk_filt && data_sync) begin
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end else if (timed_out) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = TX_IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = TX_IDLE;
            end
        endcase
    end

    // State and line enables; reset releases both lines at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            sh_q      <= '1;
            edge_q    <= '0;
            inh_q     <= '0;
            to_q      <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            edge_q    <= edge_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_busy     = (state_q != TX_IDLE);
    assign tx_done     = done_q;
    assign tx_error    = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
